// File: rtl/alert_event_queue.sv
// alert_event_queue: turns co-processor change alerts into timestamped
// events held in a small FIFO drained by a valid/read handshake. It also
// keeps per-channel saturating alert counters and a sticky overflow flag.
//
// Optional build macro: ALERT_DEDUP_EN. When it is defined, an alert on the
// same channel as the last accepted one, arriving in the cycle right after
// that accept, is ignored.
//
// Handshake: ev_valid=1 means ev_data holds the head entry. A pop happens
// at a rising edge where rd_en=1 and ev_valid=1. rd_en while empty is ignored.
module alert_event_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alert_in,
    input  logic [1:0]       alert_ch,
    input  logic             rd_en,
    output logic             ev_valid,
    output logic [7:0]       ev_data,
    output logic [2:0]       ev_count,
    output logic             overflow,
    input  logic             clr_ovf,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int AW = $clog2(DEPTH);

    logic [5:0]       ts;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [2:0]       count;
    logic [CNT_W-1:0] cnt [4];

    logic accept;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

`ifdef ALERT_DEDUP_EN
    logic       last_acc;
    logic [1:0] last_ch;

    // A repeat of the last accepted channel in the very next cycle is suppressed.
    assign accept = alert_in && !(last_acc && (alert_ch == last_ch));

    // Remember whether the previous cycle accepted an event and on which channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_acc <= 1'b0;
            last_ch  <= 2'd0;
        end else begin
            last_acc <= accept;
            if (accept) begin
                last_ch <= alert_ch;
            end
        end
    end
`else
    assign accept = alert_in;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO with rd_en still takes a push.
    assign empty = (count == 3'd0);
    assign full  = (count == 3'(DEPTH));
    assign pop   = rd_en && !empty;
    assign push  = accept && (!full || pop);
    assign drop  = accept && full && !pop;

    // Free-running timestamp; the pre-increment value tags an accepted event.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= 6'd0;
        end else begin
            ts <= ts + 6'd1;
        end
    end

    // FIFO storage: entries are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {alert_ch, ts};
        end
    end

    // Pointers wrap naturally; the occupancy count tells full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Per-channel saturating counters count every accepted event, pushed or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (alert_ch == i[1:0]) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign ev_valid = !empty;
    assign ev_data  = empty ? 8'd0 : mem[rd_ptr];
    assign ev_count = count;
    assign cnt_out  = cnt[cnt_sel];

endmodule

// File: tb/tb_alert_event_queue.sv
// tb_alert_event_queue: table-driven vectors plus a queue-based scoreboard
// for alert_event_queue (default parameters DEPTH=4, CNT_W=8).
module tb_alert_event_queue;

    logic       clk;
    logic       reset;
    logic       alert_in;
    logic [1:0] alert_ch;
    logic       rd_en;
    logic       ev_valid;
    logic [7:0] ev_data;
    logic [2:0] ev_count;
    logic       overflow;
    logic       clr_ovf;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_out;

    alert_event_queue dut (
        .clk      (clk),
        .reset    (reset),
        .alert_in (alert_in),
        .alert_ch (alert_ch),
        .rd_en    (rd_en),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_count (ev_count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [7:0] exp_q[$];
    logic [5:0] m_ts;
    logic [7:0] m_cnt [4];
    logic       m_ovf;
    logic       m_last_acc;
    logic [1:0] m_last_ch;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       a;
        logic [1:0] ch;
        logic       rd;
        logic       clr;
        logic       valid;
        logic [7:0] data;
        logic [2:0] count;
        logic       ovf;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        alert_in = 1'b0;
        alert_ch = 2'd0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_ts       = 6'd0;
        m_ovf      = 1'b0;
        m_last_acc = 1'b0;
        m_last_ch  = 2'd0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
    endtask

    // Driver: one clock cycle of stimulus; the model predicts and checks the result.
    task automatic cycle(input logic a, input logic [1:0] ch, input logic rd, input logic clr);
        logic acc;
        logic dropped;
        alert_in = a;
        alert_ch = ch;
        rd_en    = rd;
        clr_ovf  = clr;
        acc      = a;
        dropped  = 1'b0;
`ifdef ALERT_DEDUP_EN
        if (a && m_last_acc && (ch == m_last_ch)) acc = 1'b0;
        m_last_acc = acc;
        if (acc) m_last_ch = ch;
`endif
        if (rd && exp_q.size() > 0) begin
            chk("pop_data", ev_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            if (m_cnt[ch] != 8'hFF) m_cnt[ch] = m_cnt[ch] + 8'd1;
            if (exp_q.size() < 4) exp_q.push_back({ch, m_ts});
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_ts = m_ts + 6'd1;
        @(posedge clk);
        #1;
        chk("ev_count", ev_count, exp_q.size());
        chk("ev_valid", ev_valid, exp_q.size() != 0);
        chk("overflow", overflow, m_ovf);
        if (exp_q.size() == 0) chk("ev_data_empty", ev_data, 0);
    endtask

    task automatic check_cnts();
        for (int i = 0; i < 4; i++) begin
            cnt_sel = i[1:0];
            #1;
            chk("cnt_out", cnt_out, m_cnt[i]);
        end
    endtask

    initial begin
        logic [7:0] prev_d;
        logic [7:0] cur_d;
        logic       have_prev;
        int         wraps;

        n_checks = 0;
        n_fail   = 0;
        cnt_sel  = 2'd0;

        // ordering + overflow table, starting at ts=10 after reset
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd1, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd1, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd3, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd3, 1'b0};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h0A, 3'd4, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 8'h4C, 3'd3, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 8'h8E, 3'd2, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 8'hD0, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h16, 3'd1, 1'b0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'h16, 3'd2, 1'b0};
        tbl[14] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h16, 3'd3, 1'b0};
        tbl[15] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h16, 3'd4, 1'b0};
        tbl[16] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'h16, 3'd4, 1'b1};
        tbl[17] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'h57, 3'd4, 1'b1};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h57, 3'd4, 1'b0};

        // reset values
        do_reset();
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_data", ev_data, 8'h00);
        chk("rst_ev_count", ev_count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        check_cnts();

        // first event: channel 2 at ts=5
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 1'b0, 1'b0);
        chk("first_data", ev_data, 8'h85);
        chk("first_count", ev_count, 3'd1);
        chk("first_valid", ev_valid, 1'b1);
        cnt_sel = 2'd2;
        #1;
        chk("first_cnt_ch2", cnt_out, 8'd1);

        // table: order, drain, underflow, fill, overflow, pop+push when full, clear
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].a, tbl[i].ch, tbl[i].rd, tbl[i].clr);
            chk("tbl_valid", ev_valid, tbl[i].valid);
            chk("tbl_data", ev_data, tbl[i].data);
            chk("tbl_count", ev_count, tbl[i].count);
            chk("tbl_ovf", overflow, tbl[i].ovf);
        end
        check_cnts();
        cnt_sel = 2'd1;
        #1;
        chk("drop_still_counted", cnt_out, 8'd3);

        // saturation and timestamp wrap with continuous reads
        do_reset();
        have_prev = 1'b0;
        prev_d    = 8'd0;
        wraps     = 0;
        for (int i = 0; i < 300; i++) begin
            if (ev_valid) begin
                cur_d = ev_data;
                if (have_prev && prev_d[5:0] == 6'd63 && cur_d[5:0] == 6'd0) wraps++;
                prev_d    = cur_d;
                have_prev = 1'b1;
            end
            cycle(1'b1, 2'd1, 1'b1, 1'b0);
        end
        check_cnts();
`ifndef ALERT_DEDUP_EN
        cnt_sel = 2'd1;
        #1;
        chk("cnt_saturated", cnt_out, 8'd255);
        chk("ts_wrap_seen", wraps > 0, 1'b1);
`endif

        // reset with three entries queued, then a read while empty
        do_reset();
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 1'b0, 1'b0);
        chk("pre_reset_count", ev_count, 3'd3);
        do_reset();
        chk("midrst_valid", ev_valid, 1'b0);
        chk("midrst_count", ev_count, 3'd0);
        check_cnts();
        cycle(1'b0, 2'd0, 1'b1, 1'b0);
        chk("empty_rd_count", ev_count, 3'd0);
        chk("empty_rd_data", ev_data, 8'h00);

`ifdef ALERT_DEDUP_EN
        do_reset();
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        chk("dedup_count", ev_count, 3'd1);
        cnt_sel = 2'd3;
        #1;
        chk("dedup_cnt", cnt_out, 8'd1);
        do_reset();
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        chk("dedup_alt_count", ev_count, 3'd3);
`endif

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alert_event_queue.md
# alert_event_queue

Downstream consumer of the co-processor's change-alert outputs (`Q`, `Q1`). Each cycle in which an alert is asserted becomes an event: the sensor channel plus a 6-bit timestamp. Events are written into a small FIFO that a host or pin interface drains with a valid/read handshake. The block also keeps per-channel saturating alert counters and a sticky overflow flag, so no alert activity is silently lost.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, default 8: width of each per-channel alert counter.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `alert_in`  in  1: alert strobe, driven by co-processor `Q`.
- `alert_ch`  in  2: alerting channel, driven by co-processor `Q1`; sampled only when `alert_in`=1.
- `rd_en`  in  1: pop request for the head entry.
- `ev_valid`  out  1: FIFO is non-empty and `ev_data` holds the head entry.
- `ev_data`  out  8: head entry, `{ch[1:0], ts[5:0]}`; forced to 0 when the FIFO is empty.
- `ev_count`  out  3: current FIFO occupancy, 0..DEPTH (width fits DEPTH=4).
- `overflow`  out  1: sticky flag, set when an event is dropped.
- `clr_ovf`  in  1: clears `overflow`.
- `cnt_sel`  in  2: selects the channel counter shown on `cnt_out`.
- `cnt_out`  out  CNT_W: counter of the selected channel; combinational mux of registered counters.

## Operation
- Timestamp `ts`: 6-bit free-running counter, +1 every cycle, wraps 63→0. 0 out of reset.
- Accept: at a rising edge with `alert_in`=1, the event `{alert_ch, ts}` is formed, where `ts` is the value before the increment.
- Push: an accepted event is written at the tail if the FIFO is not full.
- Overflow:
  - If the FIFO is full and no pop happens in the same cycle, the event is dropped and `overflow` is set.
  - If the FIFO is full and `rd_en`=1 in the same cycle, both the pop and the push happen; nothing is dropped.
- Pop: `rd_en`=1 with `ev_valid`=1 removes the head at the edge. `rd_en` while empty is ignored; no underflow and no state change.
- Push while empty: the entry becomes the head. There is no bypass; it is visible the next cycle.
- `overflow`:
  - Cleared by `clr_ovf` or `reset`.
  - If a set condition and `clr_ovf` occur in the same cycle, the set wins.
- Counters:
  - Each accepted event increments its channel's counter, whether or not the event was pushed.
  - Counters saturate at 2^CNT_W−1 and are never cleared except by `reset`.
- Pointers: read and write pointers are log2(DEPTH) bits wide and wrap naturally. The occupancy count separates the full and empty cases.

## Timing
- Reset values: `ev_valid`=0, `ev_data`=0, `ev_count`=0, `overflow`=0, all counters 0 (so `cnt_out`=0), `ts`=0, pointers 0.
- Reset is sampled at the edge. A reset that arrives mid-stream discards all queued entries in that same cycle.
- Latency from alert edge to `ev_valid` is 1 cycle when the FIFO was empty.
- `ev_count` and `ev_valid` update at the same edge as the push or pop that changes them.
- Throughput: one push and one pop per cycle, sustained.
- `cnt_out` follows `cnt_sel` combinationally. A counter increment is visible the cycle after the accepting edge.

## Configuration
- Macro `ALERT_DEDUP_EN`.
- Defined: an alert whose channel equals the last accepted channel, and which arrives in the cycle immediately after that accept, is ignored:
  - no push, no counter increment, no overflow effect;
  - the "last accepted" record does not change.
- Undefined: every cycle with `alert_in`=1 is accepted.

## Test plan
- Reset, then drive `alert_in`=1 with `alert_ch`=2 at `ts`=5, no reads.
  - Next cycle: `ev_valid`=1, `ev_data`=8'h85, `ev_count`=1.
  - Channel-2 `cnt_out`=1.
- Drive alerts on channels 0,1,2,3 in cycles with `ts`=10,12,14,16, then pop 4 times.
  - Output order: 8'h0A, 8'h4C, 8'h8E, 8'hD0.
  - `ev_valid`=0 afterwards and `ev_data`=0.
- Fill the FIFO to 4 entries, then send one alert with `rd_en`=0 → `overflow`=1, `ev_count` stays 4, and that channel's counter still increments.
  - Next alert with `rd_en`=1 → no new drop, `ev_count`=4.
  - `clr_ovf` pulse → `overflow`=0.
- Hold alerts on channel 1 for 300 cycles with continuous reads.
  - Channel-1 `cnt_out` saturates at 255.
  - `ts` wraps from 63 to 0 in successive `ev_data` values.
- Assert `reset` while 3 entries are queued → next cycle `ev_valid`=0, `ev_count`=0 and all counters 0. Pulse `rd_en` while empty → no change.
- With `ALERT_DEDUP_EN` defined: alert on channel 3 for 2 consecutive cycles → 1 entry, counter=1.
  - Channel 3, then channel 0, then channel 3 on consecutive cycles → 3 entries.
